// File: rtl/uart_rx_if.sv
// Serial line into uart_rx and the received-byte strobes it presents downstream.
interface uart_rx_if;
    logic       i_rx;
    logic [7:0] o_rx_data;
    logic       o_rx_data_valid;
    logic       o_frame_err;
    logic       o_busy;

    modport master (
        input  i_rx,
        output o_rx_data, o_rx_data_valid, o_frame_err, o_busy
    );
    modport slave (
        output i_rx,
        input  o_rx_data, o_rx_data_valid, o_frame_err, o_busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the serial line, samples each bit at mid-period
// and emits a one-cycle valid pulse per good byte or a frame-error pulse per bad stop bit.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic      i_clk,
    input  logic      i_rst,
    uart_rx_if.master bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int H  = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_next;
    logic [CW-1:0] count, count_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [7:0]    shift, shift_next;
    logic [7:0]    data, data_next;
    logic          valid, valid_next;
    logic          err, err_next;
    logic          rx_meta, rx_s, rx_s_d;
    logic          start_edge;

    // Resetting the synchronizer low means a line stuck low must go high before a start is seen.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta <= 1'b0;
            rx_s    <= 1'b0;
            rx_s_d  <= 1'b0;
        end else begin
            rx_meta <= bus.i_rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    assign start_edge = rx_s_d & ~rx_s;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            count   <= '0;
            bit_idx <= '0;
            shift   <= '0;
            data    <= '0;
            valid   <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            data    <= data_next;
            valid   <= valid_next;
            err     <= err_next;
        end
    end

    always_comb begin
        state_next   = state;
        count_next   = count + 1'b1;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        data_next    = data;
        valid_next   = 1'b0;
        err_next     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_edge) begin
                    count_next = '0;
                    state_next = START;
                end
            end
            START: begin
                if (count == HALF_LAST) begin
                    if (rx_s) begin
                        state_next = IDLE;
                    end else begin
                        count_next   = '0;
                        bit_idx_next = '0;
                        state_next   = DATA;
                    end
                end
            end
            DATA: begin
                if (count == BIT_LAST) begin
                    count_next   = '0;
                    shift_next   = {rx_s, shift[7:1]};
                    bit_idx_next = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                // Returning to IDLE at mid-stop-bit lets a back-to-back start edge be caught.
                if (count == BIT_LAST) begin
                    count_next = '0;
                    state_next = IDLE;
                    if (rx_s) begin
                        data_next  = shift;
                        valid_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.o_rx_data       = data;
    assign bus.o_rx_data_valid = valid;
    assign bus.o_frame_err     = err;
    assign bus.o_busy          = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: each waveform sent is reduced to the levels seen
// at the receiver's mid-bit sample points, and a monitor matches every output pulse in order.
module tb_uart_rx;
    localparam int C         = 16;
    localparam int H         = C / 2;
    localparam int VALID_EVT = 0;
    localparam int ERR_EVT   = 1;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mon_on = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   busy_from = 1;
    int   busy_to = 0;
    logic [7:0] exp_data = 8'h00;
    exp_t sb[$];
    logic wave[$];

    uart_rx_if bus();

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
        end
    endtask

    task automatic build_frame(input logic [7:0] d, input int b, input logic stop);
        logic lv;
        wave.delete();
        for (int k = 0; k < 10; k++) begin
            lv = (k == 0) ? 1'b0 : ((k == 9) ? stop : d[k-1]);
            repeat (b) wave.push_back(lv);
        end
    endtask

    function automatic logic level_at(input int off);
        return (off < wave.size()) ? wave[off] : 1'b1;
    endfunction

    // wave[i] is captured by the first synchronizer flop at edge t0+i; the receiver's k-th
    // sample sees wave[H + k*C], and its result is visible right after edge t0+2+H+9*C.
    task automatic apply_stimulus();
        int         t0;
        logic [7:0] d;
        exp_t       e;
        t0 = cyc + 1;
        busy_from = t0 + 2;
        if (level_at(H)) begin
            busy_to = t0 + 1 + H;
        end else begin
            for (int k = 1; k <= 8; k++) d[k-1] = level_at(H + k * C);
            e.kind = level_at(H + 9 * C) ? VALID_EVT : ERR_EVT;
            e.data = d;
            e.due  = t0 + 2 + H + 9 * C;
            sb.push_back(e);
            busy_to = e.due - 1;
        end
        for (int i = 0; i < wave.size(); i++) begin
            bus.i_rx = wave[i];
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        bus.i_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_on) begin
            if (bus.o_rx_data_valid || bus.o_frame_err) begin
                check_output("valid_err_exclusive", {31'b0, bus.o_rx_data_valid & bus.o_frame_err}, 32'd0);
                if (sb.size() == 0) begin
                    check_output("unexpected_pulse", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_output("event_kind", bus.o_frame_err ? ERR_EVT : VALID_EVT, e.kind);
                    check_output("event_cycle", cyc, e.due);
                    if (e.kind == VALID_EVT) exp_data = e.data;
                end
            end else if (sb.size() != 0 && cyc > sb[0].due) begin
                check_output("missing_pulse", cyc, sb[0].due);
                void'(sb.pop_front());
            end
            check_output("busy", {31'b0, bus.o_busy}, {31'b0, (cyc >= busy_from) && (cyc <= busy_to)});
            check_output("rx_data", {24'b0, bus.o_rx_data}, {24'b0, exp_data});
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] partial;
        logic [7:0] rnd;
        logic       stop_rnd;
        bus.i_rx = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_output("reset_data", {24'b0, bus.o_rx_data}, 32'd0);
        check_output("reset_valid", {31'b0, bus.o_rx_data_valid}, 32'd0);
        check_output("reset_err", {31'b0, bus.o_frame_err}, 32'd0);
        check_output("reset_busy", {31'b0, bus.o_busy}, 32'd0);
        rst = 1'b0;
        mon_on = 1'b1;
        idle(10);

        $display("[TB] single frame 0xA5");
        build_frame(8'hA5, C, 1'b1);
        apply_stimulus();
        idle(30);

        $display("[TB] back-to-back 0x03, 0x0E");
        build_frame(8'h03, C, 1'b1);
        apply_stimulus();
        build_frame(8'h0E, C, 1'b1);
        apply_stimulus();
        idle(30);

        $display("[TB] 4-cycle glitch");
        wave.delete();
        repeat (4) wave.push_back(1'b0);
        apply_stimulus();
        idle(30);

        $display("[TB] good 0x12 then 0x55 with low stop bit");
        build_frame(8'h12, C, 1'b1);
        apply_stimulus();
        idle(25);
        build_frame(8'h55, C, 1'b0);
        apply_stimulus();
        idle(30);

        $display("[TB] break held low");
        wave.delete();
        repeat (400) wave.push_back(1'b0);
        apply_stimulus();
        idle(30);

        $display("[TB] reset during data bit 4");
        partial = 8'h5A;
        busy_from = cyc + 3;
        busy_to = 1 << 30;
        bus.i_rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            bus.i_rx = partial[k];
            repeat (C) @(negedge clk);
        end
        bus.i_rx = 1'b0;
        repeat (H) @(negedge clk);
        rst = 1'b1;
        busy_to = cyc;
        @(posedge clk);
        #1;
        exp_data = 8'h00;
        @(negedge clk);
        check_output("abort_data", {24'b0, bus.o_rx_data}, 32'd0);
        check_output("abort_valid", {31'b0, bus.o_rx_data_valid}, 32'd0);
        check_output("abort_err", {31'b0, bus.o_frame_err}, 32'd0);
        check_output("abort_busy", {31'b0, bus.o_busy}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        idle(20);
        build_frame(8'h3C, C, 1'b1);
        apply_stimulus();
        idle(30);

        $display("[TB] baud skew 15 and 17 cycles per bit");
        build_frame(8'h96, 15, 1'b1);
        apply_stimulus();
        idle(40);
        build_frame(8'h96, 17, 1'b1);
        apply_stimulus();
        idle(40);

        $display("[TB] random frames");
        for (int n = 0; n < 12; n++) begin
            rnd = 8'($urandom);
            stop_rnd = ($urandom_range(0, 3) != 0);
            build_frame(rnd, C, stop_rnd);
            apply_stimulus();
            idle(int'($urandom_range(20, 40)));
        end

        idle(200);
        check_output("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
